// File: rtl/shift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// shift_pipe_pkg
// Shared types and constants for the display shift pipeline controller.
//   state_e            : controller FSM states (IDLE, PEND, FLUSH)
//   TICK_DIV_50MHZ_3S  : clk cycles per tick for a 3 s tick at 50 MHz
//   PIPE_DEPTH         : default number of pipeline stages
//   clog2()            : ceil(log2(value)), usable in parameter expressions
// ---------------------------------------------------------------------------
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned TICK_DIV_50MHZ_3S = 150000000;
  localparam int unsigned PIPE_DEPTH        = 4;

  // Smallest r with 2**r >= value; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing one registered single-cycle tick every
// TICK_DIV clk cycles. The first tick after reset appears in cycle TICK_DIV.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset (count and tick cleared)
//   tick  : one-cycle pulse, high in the cycle after the count wraps
// ---------------------------------------------------------------------------
module tick_prescaler
  import shift_pipe_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_50MHZ_3S
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned   CW   = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Count 0..TICK_DIV-1 and wrap back to zero.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // The tick is registered off the terminal count so it is glitch-free and
  // lands exactly one cycle after the count reaches LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/shift_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// shift_pipe_ctrl
// Sequences a DEPTH-deep, W-bit display shift pipeline that runs on clk and
// advances only on shift_en. User pushes (active-low button) are queued until
// the next tick; a flush request drains DEPTH zeros through the pipeline.
// Ports:
//   clk        : system clock (single domain)
//   reset      : synchronous, active-high reset
//   in         : user data, captured on the press event
//   button     : active-low push button, asynchronous to clk
//   flush_req  : level request to drain the pipeline to zero
//   shift_en   : one-cycle pulse advancing the pipeline by one stage
//   shift_din  : data entering stage 0 (holds its value between shifts)
//   tick       : prescaler pulse
//   occupancy  : number of valid entries in the pipeline
//   full       : occupancy == DEPTH
//   busy       : controller is not idle
//   drop       : one-cycle pulse when a press is discarded
// ---------------------------------------------------------------------------
module shift_pipe_ctrl
  import shift_pipe_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_50MHZ_3S,
  parameter int unsigned DEPTH    = PIPE_DEPTH,
  parameter int unsigned W        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [W-1:0]                in,
  input  logic                        button,
  input  logic                        flush_req,
  output logic                        shift_en,
  output logic [W-1:0]                shift_din,
  output logic                        tick,
  output logic [clog2(DEPTH+1)-1:0]   occupancy,
  output logic                        full,
  output logic                        busy,
  output logic                        drop
);

  localparam int unsigned   OW      = clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);

  logic          tick_w;
  logic          sync1_q, sync2_q, prev_q;
  logic          press_evt;
  state_e        state_q, state_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [OW-1:0] rem_q, rem_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          shift_en_q, shift_en_d;
  logic [W-1:0]  shift_din_q, shift_din_d;
  logic          drop_q, drop_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_w)
  );

  // Button synchroniser plus a previous-value flop for falling-edge detect.
  // All reset to 1 (released) so a button already released never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press_evt = ~sync2_q & prev_q;

  // Next-state logic. A push waits in PEND for the next tick; a flush issues
  // exactly DEPTH zero shifts, one per tick. Any press that cannot be taken
  // (flush has priority in IDLE, first press wins in PEND) raises drop.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rem_d       = rem_q;
    occ_d       = occ_q;
    shift_en_d  = 1'b0;
    shift_din_d = shift_din_q;
    drop_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          rem_d   = DEPTH_V;
          drop_d  = press_evt;
        end else if (press_evt) begin
          state_d = PEND;
          hold_d  = in;
        end
      end
      PEND: begin
        drop_d = press_evt;
        if (tick_w) begin
          shift_en_d  = 1'b1;
          shift_din_d = hold_q;
          if (occ_q != DEPTH_V) begin
            occ_d = occ_q + OW'(1);
          end
          state_d = IDLE;
        end
      end
      FLUSH: begin
        drop_d = press_evt;
        if (tick_w) begin
          shift_en_d  = 1'b1;
          shift_din_d = '0;
          if (occ_q != '0) begin
            occ_d = occ_q - OW'(1);
          end
          rem_d = rem_q - OW'(1);
          if (rem_q == OW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any pending push or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rem_q       <= '0;
      occ_q       <= '0;
      shift_en_q  <= 1'b0;
      shift_din_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rem_q       <= rem_d;
      occ_q       <= occ_d;
      shift_en_q  <= shift_en_d;
      shift_din_q <= shift_din_d;
      drop_q      <= drop_d;
    end
  end

  assign tick      = tick_w;
  assign shift_en  = shift_en_q;
  assign shift_din = shift_din_q;
  assign occupancy = occ_q;
  assign full      = (occ_q == DEPTH_V);
  assign busy      = (state_q != IDLE);
  assign drop      = drop_q;

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe_ctrl
// Self-checking bench for shift_pipe_ctrl with TICK_DIV=8, DEPTH=4, W=4.
// A cycle-level behavioural model (button sample history, pending push,
// remaining flush count, occupancy integer) predicts every output; directed
// scenarios pin the model with hand-computed values, then random stimulus
// runs against it.
// ---------------------------------------------------------------------------
module tb_shift_pipe_ctrl;

  localparam int TD    = 8;
  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] in;
  logic         button;
  logic         flush_req;
  logic         shift_en;
  logic [W-1:0] shift_din;
  logic         tick;
  logic [2:0]   occupancy;
  logic         full;
  logic         busy;
  logic         drop;

  int nChecks;
  int nErrors;
  int winShifts;
  int winTicks;

  // model state
  bit modelReady;
  int mCyc;
  bit bHist[$];
  bit mPending;
  int mPendVal;
  int mFlushLeft;
  int mOcc;
  bit eTick, eShift, eDrop;
  int eDin;

  shift_pipe_ctrl #(
    .TICK_DIV (TD),
    .DEPTH    (DEPTH),
    .W        (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .button    (button),
    .flush_req (flush_req),
    .shift_en  (shift_en),
    .shift_din (shift_din),
    .tick      (tick),
    .occupancy (occupancy),
    .full      (full),
    .busy      (busy),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, mCyc);
    end
  endtask

  task automatic applyStimulus(input bit b, input logic [W-1:0] d, input bit f);
    button    = b;
    in        = d;
    flush_req = f;
  endtask

  function automatic bit sampleAt(input int idx);
    if (idx < 0) return 1'b1;
    return bHist[idx];
  endfunction

  // Behavioural model: the press that the FSM sees at an edge comes from the
  // button samples taken two and three edges earlier (low after high).
  initial begin
    bit tickNow;
    bit press;
    int n;
    modelReady = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        modelReady = 1'b1;
        mCyc       = 0;
        bHist.delete();
        mPending   = 1'b0;
        mPendVal   = 0;
        mFlushLeft = 0;
        mOcc       = 0;
        eTick      = 1'b0;
        eShift     = 1'b0;
        eDrop      = 1'b0;
        eDin       = 0;
      end else if (modelReady) begin
        tickNow = (mCyc > 0) && (mCyc % TD == 0);
        n       = bHist.size();
        press   = (sampleAt(n - 2) == 1'b0) && (sampleAt(n - 3) == 1'b1);
        bHist.push_back(button);
        eShift = 1'b0;
        eDrop  = 1'b0;
        if (mPending) begin
          if (press) eDrop = 1'b1;
          if (tickNow) begin
            eShift   = 1'b1;
            eDin     = mPendVal;
            mOcc     = (mOcc < DEPTH) ? mOcc + 1 : DEPTH;
            mPending = 1'b0;
          end
        end else if (mFlushLeft > 0) begin
          if (press) eDrop = 1'b1;
          if (tickNow) begin
            eShift     = 1'b1;
            eDin       = 0;
            mOcc       = (mOcc > 0) ? mOcc - 1 : 0;
            mFlushLeft = mFlushLeft - 1;
          end
        end else begin
          if (flush_req) begin
            mFlushLeft = DEPTH;
            if (press) eDrop = 1'b1;
          end else if (press) begin
            mPending = 1'b1;
            mPendVal = int'(in);
          end
        end
        mCyc  = mCyc + 1;
        eTick = (mCyc % TD == 0);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (modelReady) begin
        checkOutput("tick",      32'(tick),      32'(eTick));
        checkOutput("shift_en",  32'(shift_en),  32'(eShift));
        checkOutput("shift_din", 32'(shift_din), 32'(eDin));
        checkOutput("occupancy", 32'(occupancy), 32'(mOcc));
        checkOutput("full",      32'(full),      32'(mOcc == DEPTH));
        checkOutput("busy",      32'(busy),      32'(mPending || (mFlushLeft > 0)));
        checkOutput("drop",      32'(drop),      32'(eDrop));
      end
    end
  end

  task automatic runTo(input int c);
    int guard;
    guard = 0;
    while (mCyc != c && guard < 2000) begin
      @(negedge clk);
      guard++;
      winShifts += int'(shift_en);
      winTicks  += int'(tick);
    end
    if (mCyc != c) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL runTo: reached cycle %0d, wanted %0d", mCyc, c);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    winShifts = 0;
    winTicks  = 0;
  endtask

  initial begin
    int btnLeft;
    int flLeft;
    nChecks   = 0;
    nErrors   = 0;
    winShifts = 0;
    winTicks  = 0;
    reset     = 1'b1;
    applyStimulus(1'b1, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state, idle ticks and a single long-held push of A.
    checkOutput("rst_occ",  32'(occupancy), 32'd0);
    checkOutput("rst_busy", 32'(busy),      32'd0);
    checkOutput("rst_tick", 32'(tick),      32'd0);
    runTo(2);  applyStimulus(1'b0, 4'hA, 1'b0);
    runTo(4);  checkOutput("s2_busy_c4", 32'(busy), 32'd0);
    runTo(5);  checkOutput("s2_busy_c5", 32'(busy), 32'd1);
    runTo(7);  checkOutput("s1_tick_c7", 32'(tick), 32'd0);
    runTo(8);  checkOutput("s1_tick_c8", 32'(tick), 32'd1);
    checkOutput("s2_shift_c8", 32'(shift_en), 32'd0);
    runTo(9);  checkOutput("s2_shift_c9", 32'(shift_en), 32'd1);
    checkOutput("s2_din_c9", 32'(shift_din), 32'hA);
    checkOutput("s2_occ_c9", 32'(occupancy), 32'd1);
    runTo(22); applyStimulus(1'b1, 4'h0, 1'b0);
    runTo(39);
    checkOutput("s1_ticks", 32'(winTicks),  32'd4);
    checkOutput("s2_shifts", 32'(winShifts), 32'd1);

    // Second press while pending is dropped; first value wins.
    doReset();
    applyStimulus(1'b0, 4'h3, 1'b0);
    runTo(2);  applyStimulus(1'b1, 4'h3, 1'b0);
    runTo(3);  checkOutput("s4_busy_c3", 32'(busy), 32'd1);
    runTo(5);  applyStimulus(1'b0, 4'h7, 1'b0);
    runTo(6);  applyStimulus(1'b1, 4'h7, 1'b0);
    runTo(7);  checkOutput("s4_drop_c7", 32'(drop), 32'd0);
    runTo(8);  checkOutput("s4_drop_c8", 32'(drop), 32'd1);
    runTo(9);  checkOutput("s4_din_c9", 32'(shift_din), 32'h3);
    checkOutput("s4_occ_c9", 32'(occupancy), 32'd1);
    checkOutput("s4_drop_c9", 32'(drop), 32'd0);
    runTo(30);
    checkOutput("s4_shifts", 32'(winShifts), 32'd1);

    // Two pushes, then flush together with a press.
    doReset();
    applyStimulus(1'b0, 4'h5, 1'b0);
    runTo(2);  applyStimulus(1'b1, 4'h5, 1'b0);
    runTo(9);  checkOutput("s5_din_c9", 32'(shift_din), 32'h5);
    runTo(10); applyStimulus(1'b0, 4'h6, 1'b0);
    runTo(12); applyStimulus(1'b1, 4'h6, 1'b0);
    runTo(17); checkOutput("s5_occ_c17", 32'(occupancy), 32'd2);
    runTo(20); applyStimulus(1'b0, 4'h9, 1'b0);
    runTo(22); applyStimulus(1'b1, 4'h9, 1'b1);
    runTo(23); applyStimulus(1'b1, 4'h9, 1'b0);
    checkOutput("s5_drop_c23", 32'(drop), 32'd1);
    checkOutput("s5_busy_c23", 32'(busy), 32'd1);
    runTo(25); checkOutput("s5_occ_c25", 32'(occupancy), 32'd1);
    checkOutput("s5_din_c25", 32'(shift_din), 32'h0);
    runTo(33); checkOutput("s5_occ_c33", 32'(occupancy), 32'd0);
    runTo(41); checkOutput("s5_shift_c41", 32'(shift_en), 32'd1);
    runTo(48); checkOutput("s5_busy_c48", 32'(busy), 32'd1);
    runTo(49); checkOutput("s5_busy_c49", 32'(busy), 32'd0);
    runTo(56);
    checkOutput("s5_shifts", 32'(winShifts), 32'd6);

    // Reset in the middle of a flush.
    applyStimulus(1'b1, 4'h0, 1'b1);
    runTo(57); applyStimulus(1'b1, 4'h0, 1'b0);
    runTo(73); checkOutput("s6_shift_c73", 32'(shift_en), 32'd1);
    checkOutput("s6_busy_c73", 32'(busy), 32'd1);
    doReset();
    checkOutput("s6_busy_r", 32'(busy),      32'd0);
    checkOutput("s6_occ_r",  32'(occupancy), 32'd0);
    checkOutput("s6_sh_r",   32'(shift_en),  32'd0);
    runTo(1);  checkOutput("s6_sh_r1", 32'(shift_en), 32'd0);
    runTo(8);  checkOutput("s6_tick_c8", 32'(tick), 32'd1);
    checkOutput("s6_ticks", 32'(winTicks), 32'd1);
    runTo(9);  checkOutput("s6_sh_c9", 32'(shift_en), 32'd0);

    // Random stimulus against the model.
    btnLeft = 5;
    flLeft  = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 699) == 0) reset = 1'b1;
      if (btnLeft == 0) begin
        button  = ~button;
        btnLeft = button ? int'($urandom_range(3, 14)) : int'($urandom_range(1, 10));
      end else begin
        btnLeft--;
      end
      if (flLeft > 0) begin
        flLeft--;
        if (flLeft == 0) flush_req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        flush_req = 1'b1;
        flLeft    = int'($urandom_range(1, 3));
      end
      in = W'($urandom_range(0, 15));
    end
    reset = 1'b0;
    applyStimulus(1'b1, 4'h0, 1'b0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
